cpu_mem_bridge: RTL and testbench



---
 rtl/cpu_mem_bridge_if.sv | 28 ++
 rtl/cpu_mem_bridge.sv | 142 ++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_if.sv
// Bus bundle between the 8086-side requester, the bridge and the 8-bit memory controller port.
// slave is the bridge; master is whatever drives the CPU requests and answers the memory port.
interface cpu_mem_bridge_if;
  logic        cpu_req;
  logic [19:0] cpu_addr;
  logic        cpu_wide;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [25:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wide, cpu_we, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_address, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wide, cpu_we, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_address, mem_we, mem_wdata
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Splits 8086 byte/word requests into byte transactions on the memory controller's 8-bit port,
// assembling read data little-endian and returning a one-cycle done (and error) pulse.
module cpu_mem_bridge #(
  parameter logic [25:0] MEM_BASE = 26'h0100000,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic            i_clock_100_mhz,
  input  logic            i_reset,
  cpu_mem_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LO_SETUP,
    LO_WAIT,
    HI_SETUP,
    HI_WAIT,
    DONE
  } state_t;

  localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE - 1);
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  logic [19:0] addr_q;
  logic        wide_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [9:0]  cnt;

  always_ff @(posedge i_clock_100_mhz) begin
    if (i_reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      wide_q          <= 1'b0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      cnt             <= '0;
      bus.cpu_rdata   <= '0;
      bus.cpu_busy    <= 1'b0;
      bus.cpu_done    <= 1'b0;
      bus.cpu_err     <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_wdata   <= '0;
    end else begin
      bus.cpu_done <= 1'b0;
      bus.cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q          <= bus.cpu_addr;
            wide_q          <= bus.cpu_wide;
            we_q            <= bus.cpu_we;
            wdata_q         <= bus.cpu_wdata;
            bus.mem_address <= MEM_BASE + {6'b0, bus.cpu_addr};
            bus.mem_wdata   <= bus.cpu_wdata[7:0];
            bus.mem_we      <= bus.cpu_we;
            bus.cpu_busy    <= 1'b1;
            cnt             <= '0;
            state           <= LO_SETUP;
          end
        end

        LO_SETUP: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= LO_WAIT;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        // mem_we is low for the first high-byte setup cycle so the controller
        // sees a fresh write strobe between the two bytes of a word write.
        HI_SETUP: begin
          if (cnt == '0) bus.mem_we <= we_q;
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= HI_WAIT;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        LO_WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_we <= 1'b0;
            if (!we_q) bus.cpu_rdata <= {(wide_q ? bus.cpu_rdata[15:8] : 8'h00), bus.mem_rdata};
            if (wide_q) begin
              bus.mem_address <= MEM_BASE + {6'b0, addr_q + 20'd1};
              bus.mem_wdata   <= wdata_q[15:8];
              cnt             <= '0;
              state           <= HI_SETUP;
            end else begin
              bus.cpu_done <= 1'b1;
              state        <= DONE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            bus.mem_we   <= 1'b0;
            if (!we_q) bus.cpu_rdata <= wide_q ? 16'hFFFF : 16'h00FF;
            bus.cpu_done <= 1'b1;
            bus.cpu_err  <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        HI_WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_we   <= 1'b0;
            if (!we_q) bus.cpu_rdata <= {bus.mem_rdata, bus.cpu_rdata[7:0]};
            bus.cpu_done <= 1'b1;
            state        <= DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            bus.mem_we   <= 1'b0;
            if (!we_q) bus.cpu_rdata <= {8'hFF, bus.cpu_rdata[7:0]};
            bus.cpu_done <= 1'b1;
            bus.cpu_err  <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        DONE: begin
          bus.cpu_busy <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          bus.cpu_busy <= 1'b0;
          bus.mem_we   <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: expected completions and memory-port transactions are queued
// by the stimulus and checked by independent monitors on the falling edge.
module tb_cpu_mem_bridge;

  localparam int unsigned S  = 2;
  localparam int unsigned TO = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic garble = 1'b0;
  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  cpu_mem_bridge_if bus ();

  cpu_mem_bridge #(
    .MEM_BASE(26'h0100000),
    .SETTLE  (S),
    .TIMEOUT (TO)
  ) dut (
    .i_clock_100_mhz(clk),
    .i_reset        (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int unsigned cyc;
  } done_t;

  typedef struct {
    logic [25:0] addr;
    logic [7:0]  wdata;
    logic        we_first;
    logic        we_any;
  } txn_t;

  done_t done_q[$];
  txn_t  txn_q[$];

  function automatic logic [7:0] rd_map(input logic [25:0] a);
    case (a)
      26'h0100010: rd_map = 8'h5A;
      26'h01FFFFF: rd_map = 8'h11;
      26'h0100000: rd_map = 8'h22;
      26'h0100020: rd_map = 8'h3C;
      default:     rd_map = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always_comb bus.mem_rdata = garble ? 8'hEE : rd_map(bus.mem_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_txn(input logic [25:0] a, input logic [7:0] wd, input logic wf, input logic wa);
    txn_t e;
    e.addr = a; e.wdata = wd; e.we_first = wf; e.we_any = wa;
    txn_q.push_back(e);
  endtask

  task automatic exp_done(input logic [15:0] rd, input logic err, input int unsigned c);
    done_t e;
    e.rdata = rd; e.err = err; e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic close_txn(input txn_t o);
    txn_t e;
    if (txn_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL mem_txn_extra: got addr %h wdata %h, want none", o.addr, o.wdata);
    end else begin
      e = txn_q.pop_front();
      chk("mem_txn", {o.addr, o.wdata, o.we_first, o.we_any}, {e.addr, e.wdata, e.we_first, e.we_any});
    end
  endtask

  // Completion monitor.
  initial begin
    done_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cpu_done === 1'b1) begin
        if (prev_done) begin
          vectors++;
          miscompares++;
          $display("FAIL done_width: got 2+ cycle pulse, want 1 (cycle %0d)", cyc);
        end else if (done_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_extra: got cpu_done at cycle %0d, want none", cyc);
        end else begin
          e = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
          chk("cpu_err", 64'(bus.cpu_err), 64'(e.err));
        end
      end else if (bus.cpu_err === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL err_alone: got cpu_err without cpu_done, want 0 (cycle %0d)", cyc);
      end
      prev_done = (bus.cpu_done === 1'b1);
    end
  end

  // Memory-port transaction monitor: a transaction is one busy span at one address.
  initial begin
    txn_t cur;
    bit open;
    logic busy_prev;
    logic [25:0] addr_prev;
    open = 0;
    busy_prev = 1'b0;
    addr_prev = '0;
    forever begin
      @(negedge clk);
      if (bus.cpu_busy === 1'b1 && (busy_prev !== 1'b1 || bus.mem_address !== addr_prev)) begin
        if (open) close_txn(cur);
        cur.addr = bus.mem_address;
        cur.wdata = bus.mem_wdata;
        cur.we_first = bus.mem_we;
        cur.we_any = bus.mem_we;
        open = 1;
      end else if (open && bus.cpu_busy === 1'b1) begin
        cur.we_any = cur.we_any | bus.mem_we;
      end else if (open) begin
        close_txn(cur);
        open = 0;
      end
      busy_prev = bus.cpu_busy;
      addr_prev = bus.mem_address;
    end
  end

  task automatic issue(input logic [19:0] a, input logic wide, input logic we,
                       input logic [15:0] wd, output int unsigned t);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_wide = wide; bus.cpu_we = we; bus.cpu_wdata = wd;
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_addr = 20'hABCDE; bus.cpu_wide = ~wide; bus.cpu_we = ~we;
    bus.cpu_wdata = 16'hDEAD;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((done_q.size() != 0 || bus.cpu_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got no completion in %0d cycles, want completion", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned t;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wide = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_wdata = '0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {bus.cpu_rdata, bus.cpu_busy, bus.cpu_done, bus.cpu_err, bus.mem_address, bus.mem_we, bus.mem_wdata},
        '0);
    rst = 1'b0;

    // Byte read
    exp_txn(26'h0100010, 8'h00, 1'b0, 1'b0);
    issue(20'h00010, 1'b0, 1'b0, 16'h0000, t);
    exp_done(16'h005A, 1'b0, t + S + 1);
    wait_idle(100);

    // Word write at odd address; rdata untouched
    exp_txn(26'h0112345, 8'hEF, 1'b1, 1'b1);
    exp_txn(26'h0112346, 8'hBE, 1'b0, 1'b1);
    issue(20'h12345, 1'b1, 1'b1, 16'hBEEF, t);
    exp_done(16'h005A, 1'b0, t + 2 * S + 2);
    wait_idle(100);

    // Word read wrapping the 20-bit space
    exp_txn(26'h01FFFFF, 8'h00, 1'b0, 1'b0);
    exp_txn(26'h0100000, 8'h00, 1'b0, 1'b0);
    issue(20'hFFFFF, 1'b1, 1'b0, 16'h0000, t);
    exp_done(16'h2211, 1'b0, t + 2 * S + 2);
    wait_idle(100);

    // Back-to-back byte reads with cpu_req held high
    exp_txn(26'h0100040, 8'h00, 1'b0, 1'b0);
    exp_txn(26'h0100040, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 20'h00040; bus.cpu_wide = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_wdata = 16'h0000;
    @(posedge clk);
    #1 t = cyc;
    exp_done(16'h00E5, 1'b0, t + S + 1);
    exp_done(16'h00E5, 1'b0, t + 2 * S + 4);
    while (cyc < t + S + 3) @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_idle(100);

    // Stall: ready low for 50 cycles of LO_WAIT, data garbage until ready rises
    bus.mem_ready = 1'b0;
    garble = 1'b1;
    exp_txn(26'h0100020, 8'h00, 1'b0, 1'b0);
    issue(20'h00020, 1'b0, 1'b0, 16'h0000, t);
    exp_done(16'h003C, 1'b0, t + S + 1 + 50);
    while (cyc < t + S + 50) @(negedge clk);
    bus.mem_ready = 1'b1;
    garble = 1'b0;
    wait_idle(200);

    // Timeout on the low byte of a word read; no high access follows
    bus.mem_ready = 1'b0;
    exp_txn(26'h0100200, 8'h00, 1'b0, 1'b0);
    issue(20'h00200, 1'b1, 1'b0, 16'h0000, t);
    exp_done(16'hFFFF, 1'b1, t + S + TO);
    wait_idle(TO + 100);
    bus.mem_ready = 1'b1;

    // Byte write leaves rdata at the timeout value
    exp_txn(26'h0100300, 8'hAB, 1'b1, 1'b1);
    issue(20'h00300, 1'b0, 1'b1, 16'h77AB, t);
    exp_done(16'hFFFF, 1'b0, t + S + 1);
    wait_idle(100);

    // Reset during HI_WAIT of a word write: no completion expected
    exp_txn(26'h0100400, 8'h34, 1'b1, 1'b1);
    exp_txn(26'h0100401, 8'h12, 1'b0, 1'b1);
    issue(20'h00400, 1'b1, 1'b1, 16'h1234, t);
    while (cyc < t + 2 * S + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_midop", {bus.mem_we, bus.cpu_busy, bus.cpu_done}, 3'b000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal byte read after the abort
    exp_txn(26'h0100010, 8'h00, 1'b0, 1'b0);
    issue(20'h00010, 1'b0, 1'b0, 16'h0000, t);
    exp_done(16'h005A, 1'b0, t + S + 1);
    wait_idle(100);

    repeat (3) @(negedge clk);
    chk("queues_drained", {32'(done_q.size()), 32'(txn_q.size())}, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
